// File: rtl/mdu_pkg.sv
// mdu_pkg: shared FSM states, RISC-V M-extension opcodes and opcode decode helpers.
package mdu_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, DONE} mdu_state_t;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;
  function automatic logic isDiv(input logic [2:0] op);
    return !(op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU});
  endfunction
  function automatic logic isSignedDiv(input logic [2:0] op);
    return op inside {OP_DIV, OP_REM};
  endfunction
  function automatic logic isHighSel(input logic [2:0] op);
    return op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
  endfunction
endpackage

// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: issue handshake and datapath strobes between issue logic, sequencer and datapath.
interface mdu_sequencer_if #(
  parameter int OPCODE_WIDTH = 3,
  parameter int CNT_WIDTH    = 5
);
  logic                    start;
  logic [OPCODE_WIDTH-1:0] opCode;
  logic                    flush;
  logic                    divisorZero;
  logic                    ready;
  logic                    loadRegs;
  logic                    iterEn;
  logic [CNT_WIDTH-1:0]    iterCnt;
  logic                    lastIter;
  logic                    fixEn;
  logic [OPCODE_WIDTH-1:0] opCodeReg;
  logic                    selHigh;
  logic                    done;
  logic                    div0;
  modport master (
    output start, opCode, flush, divisorZero,
    input  ready, loadRegs, iterEn, iterCnt, lastIter, fixEn, opCodeReg, selHigh, done, div0
  );
  modport slave (
    input  start, opCode, flush, divisorZero,
    output ready, loadRegs, iterEn, iterCnt, lastIter, fixEn, opCodeReg, selHigh, done, div0
  );
endinterface

// File: rtl/mdu_iter_counter.sv
// mdu_iter_counter: iteration index, cleared on load, saturating at PAR-1.
module mdu_iter_counter #(
  parameter int PAR       = 32,
  parameter int CNT_WIDTH = $clog2(PAR)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic                 o_term
);
  logic [CNT_WIDTH-1:0] r_cnt;
  assign o_cnt  = r_cnt;
  assign o_term = r_cnt == CNT_WIDTH'(PAR - 1);
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_cnt <= '0;
    else if (i_en && !o_term) r_cnt <= r_cnt + CNT_WIDTH'(1);
  end
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: control FSM for the iterative radix-2 multiply/divide unit.
// Define MDU_DIV0_BYPASS_EN to skip iterations on divide-by-zero and flag div0.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int PAR          = 32,
  parameter int OPCODE_WIDTH = 3,
  parameter int CNT_WIDTH    = $clog2(PAR)
) (
  input logic            clk,
  input logic            rst,
  mdu_sequencer_if.slave bus
);
  mdu_state_t              r_state, w_next;
  logic [OPCODE_WIDTH-1:0] r_op;
  logic                    r_sel;
  logic                    w_accept, w_term, w_bypass;
  logic [CNT_WIDTH-1:0]    w_cnt;
  assign w_accept = r_state == IDLE && bus.start && !bus.flush;
`ifdef MDU_DIV0_BYPASS_EN
  logic r_div0;
  assign w_bypass = isDiv(r_op) && bus.divisorZero;
  always_ff @(posedge clk) begin
    if (rst || w_accept) r_div0 <= 1'b0;
    else if (r_state == LOAD) r_div0 <= w_bypass;
  end
  assign bus.div0 = r_state == DONE && r_div0;
`else
  assign w_bypass = bus.divisorZero & 1'b0;
  assign bus.div0 = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op  <= bus.opCode;
        r_sel <= isHighSel(bus.opCode);
      end
    end
  end
  always_comb begin
    w_next = IDLE;
    unique case (r_state)
      IDLE:    w_next = w_accept ? LOAD : IDLE;
      LOAD:    w_next = bus.flush ? IDLE : w_bypass ? DONE : ITER;
      ITER:    w_next = bus.flush ? IDLE : !w_term ? ITER : isSignedDiv(r_op) ? FIX : DONE;
      FIX:     w_next = bus.flush ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  mdu_iter_counter #(.PAR(PAR), .CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (r_state == LOAD),
    .i_en   (r_state == ITER),
    .o_cnt  (w_cnt),
    .o_term (w_term)
  );
  assign bus.ready     = r_state == IDLE;
  assign bus.loadRegs  = r_state == LOAD;
  assign bus.iterEn    = r_state == ITER;
  assign bus.iterCnt   = w_cnt;
  assign bus.lastIter  = r_state == ITER && w_term;
  assign bus.fixEn     = r_state == FIX;
  assign bus.done      = r_state == DONE;
  assign bus.opCodeReg = r_op;
  assign bus.selHigh   = r_sel;
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed checks of MDU sequencer timing, flush, reset and div0 handling.
module tb_mdu_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0, bad = 0;
  int load_c, iter_first, iter_n, last_c, fix_c, fix_n, done_c, done_n, multi, k;
  logic div0_at, sel_at, rdy_after, ready0;
  logic [2:0] opc_end;
  always #5 clk = ~clk;
  mdu_sequencer_if #(.OPCODE_WIDTH(3), .CNT_WIDTH(5)) bus ();
  mdu_sequencer #(.PAR(32), .OPCODE_WIDTH(3), .CNT_WIDTH(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic run_op(input logic [2:0] op, input logic dz, input int pulse_at);
    load_c = -1; iter_first = -1; iter_n = 0; last_c = -1; fix_c = -1; fix_n = 0;
    done_c = -1; done_n = 0; multi = 0; div0_at = 0; sel_at = 0; rdy_after = 0;
    @(negedge clk);
    ready0 = bus.ready; bus.opCode = op; bus.divisorZero = dz; bus.start = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.loadRegs && load_c < 0) load_c = c;
      if (bus.iterEn) begin iter_n++; if (iter_first < 0) iter_first = c; end
      if (bus.lastIter) last_c = c;
      if (bus.fixEn) begin fix_n++; fix_c = c; end
      if (bus.done) begin done_n++; done_c = c; div0_at = bus.div0; sel_at = bus.selHigh; end
      if (done_c == c - 1) rdy_after = bus.ready;
      if ($countones({bus.loadRegs, bus.iterEn, bus.fixEn, bus.done}) > 1) multi++;
      if (pulse_at >= 0 && bus.iterEn && int'(bus.iterCnt) == pulse_at) bus.start = 1'b1;
    end
    bus.divisorZero = 1'b0;
    opc_end = bus.opCodeReg;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({bus.ready, bus.loadRegs, bus.iterEn, bus.lastIter, bus.fixEn, bus.done, bus.div0,
         bus.selHigh, bus.iterCnt, bus.opCodeReg} !== 16'h8000) begin
      bad++; $display("FAIL reset_outputs got=%h exp=8000", {bus.ready, bus.loadRegs, bus.iterEn,
        bus.lastIter, bus.fixEn, bus.done, bus.div0, bus.selHigh, bus.iterCnt, bus.opCodeReg});
    end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    run_op(3'b000, 1'b0, -1);
    total++; if (ready0 !== 1'b1) begin bad++; $display("FAIL mul_ready0 got=%b exp=1", ready0); end
    total++; if (load_c != 1) begin bad++; $display("FAIL mul_load got=%0d exp=1", load_c); end
    total++; if (iter_first != 2) begin bad++; $display("FAIL mul_iter_first got=%0d exp=2", iter_first); end
    total++; if (iter_n != 32) begin bad++; $display("FAIL mul_iter_n got=%0d exp=32", iter_n); end
    total++; if (last_c != 33) begin bad++; $display("FAIL mul_last got=%0d exp=33", last_c); end
    total++; if (done_c != 34 || done_n != 1) begin bad++; $display("FAIL mul_done got=%0d/%0d exp=34/1", done_c, done_n); end
    total++; if (fix_n != 0) begin bad++; $display("FAIL mul_fix got=%0d exp=0", fix_n); end
    total++; if (sel_at !== 1'b0) begin bad++; $display("FAIL mul_sel got=%b exp=0", sel_at); end
    total++; if (rdy_after !== 1'b1) begin bad++; $display("FAIL mul_ready_after got=%b exp=1", rdy_after); end
    total++; if (multi != 0) begin bad++; $display("FAIL mul_exclusive got=%0d exp=0", multi); end
  endtask

  task automatic test_div();
    run_op(3'b100, 1'b0, -1);
    total++; if (fix_n != 1 || fix_c != 34) begin bad++; $display("FAIL div_fix got=%0d/%0d exp=34/1", fix_c, fix_n); end
    total++; if (done_c != 35) begin bad++; $display("FAIL div_done got=%0d exp=35", done_c); end
    total++; if (multi != 0) begin bad++; $display("FAIL div_exclusive got=%0d exp=0", multi); end
    total++; if (opc_end !== 3'b100) begin bad++; $display("FAIL div_opreg got=%b exp=100", opc_end); end
  endtask

  task automatic test_remu();
    run_op(3'b111, 1'b0, -1);
    total++; if (fix_n != 0) begin bad++; $display("FAIL remu_fix got=%0d exp=0", fix_n); end
    total++; if (done_c != 34) begin bad++; $display("FAIL remu_done got=%0d exp=34", done_c); end
    total++; if (sel_at !== 1'b1) begin bad++; $display("FAIL remu_sel got=%b exp=1", sel_at); end
  endtask

  task automatic test_start_ignored();
    run_op(3'b101, 1'b0, 5);
    total++; if (done_n != 1 || done_c != 34) begin bad++; $display("FAIL ign_done got=%0d/%0d exp=34/1", done_c, done_n); end
    total++; if (load_c != 1) begin bad++; $display("FAIL ign_load got=%0d exp=1", load_c); end
  endtask

  task automatic test_div0();
    run_op(3'b100, 1'b1, -1);
`ifdef MDU_DIV0_BYPASS_EN
    total++; if (done_c != 2 || done_n != 1) begin bad++; $display("FAIL div0_done got=%0d/%0d exp=2/1", done_c, done_n); end
    total++; if (div0_at !== 1'b1) begin bad++; $display("FAIL div0_flag got=%b exp=1", div0_at); end
    total++; if (iter_n != 0) begin bad++; $display("FAIL div0_iter got=%0d exp=0", iter_n); end
`else
    total++; if (done_c != 35 || done_n != 1) begin bad++; $display("FAIL div0_done got=%0d/%0d exp=35/1", done_c, done_n); end
    total++; if (div0_at !== 1'b0) begin bad++; $display("FAIL div0_flag got=%b exp=0", div0_at); end
    total++; if (iter_n != 32) begin bad++; $display("FAIL div0_iter got=%0d exp=32", iter_n); end
`endif
  endtask

  task automatic test_flush();
    int seen_done = 0;
    @(negedge clk); bus.opCode = 3'b001; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    k = 0;
    while (k < 50 && !(bus.iterEn && bus.iterCnt == 5'd10)) begin @(negedge clk); k++; end
    bus.flush = 1'b1;
    @(negedge clk); bus.flush = 1'b0;
    if (bus.done) seen_done++;
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", bus.ready); end
    total++; if (seen_done != 0) begin bad++; $display("FAIL flush_nodone got=%0d exp=0", seen_done); end
    total++; if (bus.opCodeReg !== 3'b001) begin bad++; $display("FAIL flush_opreg got=%b exp=001", bus.opCodeReg); end
    bus.opCode = 3'b011; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    total++; if ({bus.loadRegs, bus.opCodeReg, bus.selHigh} !== 5'b1_011_1) begin
      bad++; $display("FAIL flush_restart got=%b exp=10111", {bus.loadRegs, bus.opCodeReg, bus.selHigh}); end
    k = 1;
    while (k < 50 && !bus.done) begin @(negedge clk); k++; end
    total++; if (k != 34) begin bad++; $display("FAIL flush_restart_done got=%0d exp=34", k); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); bus.opCode = 3'b000; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    k = 1;
    while (k < 50 && !bus.done) begin @(negedge clk); k++; end
    total++; if (k != 34) begin bad++; $display("FAIL b2b_first_done got=%0d exp=34", k); end
    @(negedge clk);
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", bus.ready); end
    bus.opCode = 3'b110; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    total++; if ({bus.loadRegs, bus.opCodeReg, bus.selHigh} !== 5'b1_110_1) begin
      bad++; $display("FAIL b2b_accept got=%b exp=11101", {bus.loadRegs, bus.opCodeReg, bus.selHigh}); end
    k = 1;
    while (k < 50 && !bus.done) begin @(negedge clk); k++; end
    total++; if (k != 35) begin bad++; $display("FAIL b2b_second_done got=%0d exp=35", k); end
  endtask

  task automatic test_rst_in_fix();
    @(negedge clk); bus.opCode = 3'b110; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    k = 1;
    while (k < 50 && !bus.fixEn) begin @(negedge clk); k++; end
    total++; if (k != 34) begin bad++; $display("FAIL rst_fix_cycle got=%0d exp=34", k); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    total++;
    if ({bus.ready, bus.loadRegs, bus.iterEn, bus.lastIter, bus.fixEn, bus.done, bus.div0,
         bus.selHigh, bus.iterCnt, bus.opCodeReg} !== 16'h8000) begin
      bad++; $display("FAIL rst_fix_outputs got=%h exp=8000", {bus.ready, bus.loadRegs, bus.iterEn,
        bus.lastIter, bus.fixEn, bus.done, bus.div0, bus.selHigh, bus.iterCnt, bus.opCodeReg});
    end
    bus.opCode = 3'b001; bus.start = 1'b1; bus.flush = 1'b1;
    @(negedge clk); bus.start = 1'b0; bus.flush = 1'b0;
    total++; if ({bus.ready, bus.loadRegs, bus.opCodeReg} !== 5'b10_000) begin
      bad++; $display("FAIL start_flush_idle got=%b exp=10000", {bus.ready, bus.loadRegs, bus.opCodeReg}); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.opCode = 3'b000; bus.flush = 1'b0; bus.divisorZero = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_remu();
    test_start_ignored();
    test_div0();
    test_flush();
    test_back_to_back();
    test_rst_in_fix();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
